// File: rtl/mac_seq_ctrl.sv
// Purpose: job sequencer for the matrix-vector MAC datapath (load, then per column: clear, N_MAC ALU cycles, result handoff).
// Latency: with load/result handshakes immediate, a RELOAD=0 job raises done at 2+N_COL*(N_MAC+2) cycles after start_in is sampled.
// Backpressure: res_valid, col_idx and the whole column loop hold in OUT until res_ready; abort overrides everything outside IDLE.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start_in          job request, sampled in IDLE only
//   xload_done        input-load unit finished, sampled in LOAD only
//   abort             cancel the running job (ignored in IDLE)
//   res_ready         result writer accepts the column result
//   input_load_en     high in LOAD
//   acc_clr           high in CLR
//   alu_en            high in MAC
//   mac_idx           current MAC step, 0..N_MAC-1
//   col_idx           current column, 0..N_COL-1
//   res_valid         high in OUT
//   busy              high in every state except IDLE
//   done              one-cycle pulse at the end of a completed job
module mac_seq_ctrl #(
  parameter int N_COL  = 4,
  parameter int N_MAC  = 8,
  parameter int RELOAD = 0,
  localparam int CW = (N_COL > 1) ? $clog2(N_COL) : 1,
  localparam int MW = (N_MAC > 1) ? $clog2(N_MAC) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_in,
  input  logic          xload_done,
  input  logic          abort,
  input  logic          res_ready,
  output logic          input_load_en,
  output logic          acc_clr,
  output logic          alu_en,
  output logic [MW-1:0] mac_idx,
  output logic [CW-1:0] col_idx,
  output logic          res_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [MW-1:0] MAC_LAST = MW'(N_MAC - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N_COL - 1);

  state_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      col_idx <= '0;
      mac_idx <= '0;
    end else if (abort && (state != S_IDLE)) begin
      // Abort wins over any handshake in the same cycle, so no count moves.
      state   <= S_IDLE;
      col_idx <= '0;
      mac_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          col_idx <= '0;
          mac_idx <= '0;
          if (start_in) state <= S_LOAD;
        end
        S_LOAD: begin
          if (xload_done) state <= S_CLR;
        end
        S_CLR: begin
          mac_idx <= '0;
          state   <= S_MAC;
        end
        S_MAC: begin
          if (mac_idx == MAC_LAST) begin
            mac_idx <= '0;
            state   <= S_OUT;
          end else begin
            mac_idx <= mac_idx + 1'b1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            if (col_idx == COL_LAST) begin
              state <= S_DONE;
            end else begin
              col_idx <= col_idx + 1'b1;
              state   <= (RELOAD != 0) ? S_LOAD : S_CLR;
            end
          end
        end
        S_DONE: begin
          col_idx <= '0;
          state   <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          col_idx <= '0;
          mac_idx <= '0;
        end
      endcase
    end
  end

  // Moore decode of the state register only; no input feeds an output.
  assign input_load_en = (state == S_LOAD);
  assign acc_clr       = (state == S_CLR);
  assign alu_en        = (state == S_MAC);
  assign res_valid     = (state == S_OUT);
  assign done          = (state == S_DONE);
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Purpose: self-checking bench for mac_seq_ctrl across three parameter sets.
// Latency: expected done cycles and column order come from the bench's own timing model.
// Backpressure: res_ready is stalled on one column to check hold-off of res_valid/col_idx.
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // default instance: N_COL=4, N_MAC=8, RELOAD=0
  logic start0, xld0, ab0, rdy0, ld0, clr0, alu0, vld0, busy0, done0;
  logic [2:0] mac0;
  logic [1:0] col0;
  // reload instance: N_COL=2, N_MAC=3, RELOAD=1
  logic start1, xld1, ab1, rdy1, ld1, clr1, alu1, vld1, busy1, done1;
  logic [1:0] mac1;
  logic [0:0] col1;
  // minimal instance: N_COL=1, N_MAC=1
  logic start2, xld2, ab2, rdy2, ld2, clr2, alu2, vld2, busy2, done2;
  logic [0:0] mac2;
  logic [0:0] col2;

  mac_seq_ctrl #(.N_COL(4), .N_MAC(8), .RELOAD(0)) u_d0 (
    .clk(clk), .rst(rst), .start_in(start0), .xload_done(xld0), .abort(ab0),
    .res_ready(rdy0), .input_load_en(ld0), .acc_clr(clr0), .alu_en(alu0),
    .mac_idx(mac0), .col_idx(col0), .res_valid(vld0), .busy(busy0), .done(done0));

  mac_seq_ctrl #(.N_COL(2), .N_MAC(3), .RELOAD(1)) u_d1 (
    .clk(clk), .rst(rst), .start_in(start1), .xload_done(xld1), .abort(ab1),
    .res_ready(rdy1), .input_load_en(ld1), .acc_clr(clr1), .alu_en(alu1),
    .mac_idx(mac1), .col_idx(col1), .res_valid(vld1), .busy(busy1), .done(done1));

  mac_seq_ctrl #(.N_COL(1), .N_MAC(1), .RELOAD(0)) u_d2 (
    .clk(clk), .rst(rst), .start_in(start2), .xload_done(xld2), .abort(ab2),
    .res_ready(rdy2), .input_load_en(ld2), .acc_clr(clr2), .alu_en(alu2),
    .mac_idx(mac2), .col_idx(col2), .res_valid(vld2), .busy(busy2), .done(done2));

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  task automatic check(input string tag, input int got, input int expv);
    n_chk++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Runs one job on the default instance. stall_col<0 disables backpressure,
  // ab_col<0 disables abort. Expected column order goes to the scoreboard.
  task automatic run0(input int stall_col, input int stall_n, input int ab_col, input int ab_mac,
                      output int done_at, output int n_clr, output int n_alu, output int n_busy,
                      output int n_vld_stall, output int seq_err);
    int  stall_left, run, nexp;
    bit  prev_clr, prev_alu, aborted;
    done_at = -1; n_clr = 0; n_alu = 0; n_busy = 0; n_vld_stall = 0; seq_err = 0;
    stall_left = stall_n; run = 0; prev_clr = 0; prev_alu = 0; aborted = 0;
    nexp = (ab_col >= 0) ? ab_col : 4;
    for (int i = 0; i < nexp; i++) exp_q.push_back(i);
    rdy0 = 1'b1; xld0 = 1'b1; ab0 = 1'b0;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    for (int k = 1; k <= 120 && done_at < 0; k++) begin
      @(negedge clk);
      if (aborted) begin
        check("abort_busy", int'(busy0), 0);
        check("abort_cnt", int'({mac0, col0}), 0);
        check("abort_done", int'(done0), 0);
        ab0 = 1'b0;
        break;
      end
      if (clr0) n_clr++;
      if (alu0) begin
        n_alu++;
        run++;
        if (!prev_alu && !prev_clr) seq_err++;
      end else if (prev_alu) begin
        if (run != 8) seq_err++;
        run = 0;
      end
      prev_clr = clr0;
      prev_alu = alu0;
      if (busy0) n_busy++;
      if (done0) done_at = k;
      if (vld0) begin
        if (int'(col0) == stall_col) n_vld_stall++;
        if (int'(col0) == stall_col && stall_left > 0) begin
          rdy0 = 1'b0;
          stall_left--;
        end else begin
          rdy0 = 1'b1;
          if (exp_q.size() == 0) check("sb_underflow", 0, 1);
          else check("out_col", int'(col0), exp_q.pop_front());
        end
      end else begin
        rdy0 = 1'b1;
      end
      if (ab_col >= 0 && alu0 && int'(col0) == ab_col && int'(mac0) == ab_mac) begin
        ab0 = 1'b1;
        aborted = 1'b1;
      end
    end
  endtask

  int d, c, a, b, s, e, n_ld, n_ldp, ld_run, n_done;
  bit found;

  initial begin
    rst = 1'b0;
    {start0, xld0, ab0, rdy0} = 4'b0;
    {start1, xld1, ab1} = 3'b0; rdy1 = 1'b1;
    start2 = 1'b0; xld2 = 1'b1; ab2 = 1'b0; rdy2 = 1'b1;
    #12;
    check("rst_d0", int'({ld0, clr0, alu0, vld0, busy0, done0, mac0, col0}), 0);
    check("rst_d1", int'({ld1, clr1, alu1, vld1, busy1, done1, mac1, col1}), 0);
    check("rst_d2", int'({ld2, clr2, alu2, vld2, busy2, done2, mac2, col2}), 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    // Full default job.
    run0(-1, 0, -1, 0, d, c, a, b, s, e);
    check("job_done_cyc", d, 42);
    check("job_clr", c, 4);
    check("job_alu", a, 32);
    check("job_busy", b, 42);
    check("job_seq", e, 0);
    check("job_sb_left", exp_q.size(), 0);
    @(negedge clk);
    check("job_idle", int'(busy0), 0);

    // Backpressure on column 1.
    run0(1, 5, -1, 0, d, c, a, b, s, e);
    check("bp_done_cyc", d, 47);
    check("bp_vld_hold", s, 6);
    check("bp_busy", b, 47);
    check("bp_sb_left", exp_q.size(), 0);
    @(negedge clk);

    // Abort in column 2 at mac_idx 4, then a clean job.
    run0(-1, 0, 2, 4, d, c, a, b, s, e);
    check("ab_no_done", d, -1);
    check("ab_clr", c, 3);
    check("ab_sb_left", exp_q.size(), 0);
    run0(-1, 0, -1, 0, d, c, a, b, s, e);
    check("ab_rerun_done", d, 42);
    exp_q.delete();
    @(negedge clk);

    // abort together with start in IDLE still starts; abort in LOAD cancels.
    ab0 = 1'b1; start0 = 1'b1; xld0 = 1'b0;
    @(negedge clk);
    start0 = 1'b0;
    check("idle_abort_start", int'(ld0), 1);
    @(negedge clk);
    ab0 = 1'b0;
    check("load_abort", int'(busy0), 0);

    // start_in ignored in LOAD and MAC, then async reset mid-MAC.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start0 = 1'b1;
      check("load_hold", int'({ld0, col0}), 4);
    end
    start0 = 1'b0; xld0 = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (alu0 && mac0 == 3'd2) found = 1'b1;
    end
    check("reach_mac2", int'(found), 1);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("mac_ignore_start", int'({alu0, mac0}), 8 + 3);
    #2 rst = 1'b0;
    #1;
    check("async_rst", int'({ld0, clr0, alu0, vld0, busy0, done0, mac0, col0}), 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("rst_no_resume", int'(busy0), 0);

    // RELOAD=1, N_COL=2, N_MAC=3; xload_done two cycles after each LOAD entry.
    exp_q.push_back(0); exp_q.push_back(1);
    n_ld = 0; n_ldp = 0; ld_run = 0; n_done = 0; d = -1; a = 0;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ld1) begin
        ld_run++;
        n_ld++;
        if (ld_run == 1) n_ldp++;
      end else begin
        ld_run = 0;
      end
      xld1 = (ld_run >= 3);
      if (alu1) a++;
      if (done1) begin
        n_done++;
        if (d < 0) d = k;
      end
      if (vld1 && rdy1) begin
        if (exp_q.size() == 0) check("rl_sb_underflow", 0, 1);
        else check("rl_col", int'(col1), exp_q.pop_front());
      end
    end
    check("rl_load_pulses", n_ldp, 2);
    check("rl_load_cycles", n_ld, 6);
    check("rl_done_count", n_done, 1);
    check("rl_done_cyc", d, 17);
    check("rl_alu", a, 6);
    check("rl_sb_left", exp_q.size(), 0);

    // N_COL=1, N_MAC=1: exact state sequence {load,clr,alu,valid,done}.
    exp_q.delete();
    exp_q.push_back(5'b10000); exp_q.push_back(5'b01000); exp_q.push_back(5'b00100);
    exp_q.push_back(5'b00010); exp_q.push_back(5'b00001);
    d = -1;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done2 && d < 0) d = k;
      if (k <= 5) check("min_seq", int'({ld2, clr2, alu2, vld2, done2}), exp_q.pop_front());
    end
    check("min_done_cyc", d, 5);
    check("min_idle", int'(busy2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
